// File: rtl/sm4_pkg.sv
// ============================================================================
// sm4_pkg : shared widths and helpers for the SM4 output-buffer slice
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package sm4_pkg;

  localparam int SM4_BLK_W    = 128;
  localparam int SM4_OUT_W_32 = 32;
  localparam int SM4_OUT_W_64 = 64;
  localparam int SM4_OUT_W_128 = 128;

  function automatic int sm4_beats(input int out_w);
    return SM4_BLK_W / out_w;
  endfunction

  function automatic bit sm4_out_w_legal(input int out_w);
    return (out_w == SM4_OUT_W_32) || (out_w == SM4_OUT_W_64) || (out_w == SM4_OUT_W_128);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm4_outbuf_fifo.sv
// ============================================================================
// sm4_outbuf_fifo : show-ahead FIFO of result blocks with registered full flag
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sm4_outbuf_fifo
  import sm4_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = SM4_BLK_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [W-1:0]                 i_data,
  output logic [W-1:0]                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);

  logic [W-1:0]      r_mem [DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [c_CW-1:0]   w_count_nxt;
  logic              r_full;

  always_comb begin
    w_count_nxt = r_count;
    if (i_push && !i_pop)
      w_count_nxt = r_count + c_CW'(1);
    else if (!i_push && i_pop)
      w_count_nxt = r_count - c_CW'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;

endmodule

`default_nettype wire

// File: rtl/sm4_out_buffer.sv
// ============================================================================
// sm4_out_buffer : captures SM4 result strobes and serializes them MSB-first
// Optional status ports (level, drop_cnt) under SM4_OUTBUF_STATUS_EN. Rev 1.0
// ============================================================================
`default_nettype none

module sm4_out_buffer
  import sm4_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OUT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SM4_BLK_W-1:0]   blk_in,
  input  logic                   blk_valid_in,
  output logic [OUT_W-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   full,
  output logic                   overflow,
  input  logic                   ovf_clr
`ifdef SM4_OUTBUF_STATUS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int c_BEATS = sm4_beats(OUT_W);
  localparam int c_BW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam int c_CW    = $clog2(DEPTH+1);
  localparam logic [c_BW-1:0] c_LAST = c_BW'(c_BEATS-1);

  logic [SM4_BLK_W-1:0]           w_head;
  logic [c_BEATS-1:0][OUT_W-1:0]  w_slices;
  logic [c_CW-1:0]                w_count;
  logic                           w_full;
  logic                           w_valid;
  logic                           w_hs;
  logic                           w_pop;
  logic                           w_push;
  logic                           w_drop;
  logic [c_BW-1:0]                r_beat;
  logic                           r_overflow;

  assign w_valid = (w_count != '0);
  assign w_hs    = w_valid && m_ready;
  assign w_pop   = w_hs && (r_beat == c_LAST);
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_push  = blk_valid_in && (!w_full || w_pop);
  assign w_drop  = blk_valid_in && !w_push;

  sm4_outbuf_fifo #(
    .DEPTH (DEPTH),
    .W     (SM4_BLK_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (blk_in),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_beat <= '0;
    else if (w_hs)
      r_beat <= w_pop ? '0 : r_beat + c_BW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_overflow <= 1'b0;
    else if (w_drop)
      r_overflow <= 1'b1;
    else if (ovf_clr)
      r_overflow <= 1'b0;
  end

  // Highest slice index holds the MSBs, so beat 0 maps to the top slice.
  assign w_slices = w_head;
  assign m_data   = w_valid ? w_slices[c_LAST - r_beat] : '0;
  assign m_valid  = w_valid;
  assign m_last   = w_valid && (r_beat == c_LAST);
  assign full     = w_full;
  assign overflow = r_overflow;

`ifdef SM4_OUTBUF_STATUS_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_drop_cnt <= '0;
    else if (w_drop) begin
      if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end else if (ovf_clr)
      r_drop_cnt <= '0;
  end

  assign level    = w_count;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire
